// File: rtl/hilo_mult_ctrl_pkg.sv
// HI/LO controller shared types: op encodings, FSM states, widths.
// Imported by the controller, its interface and the bench.
package hilo_mult_ctrl_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_MFHI  = 3'd3,
      OP_MFLO  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6
   } op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_e;

   function automatic logic is_mult(op_e t);
      return (t == OP_MULT) || (t == OP_MULTU);
   endfunction

   function automatic logic is_mf(op_e t);
      return (t == OP_MFHI) || (t == OP_MFLO);
   endfunction

endpackage

// File: rtl/hilo_mult_ctrl_if.sv
// EXE-stage HI/LO op handshake: pipeline (master) to controller (slave).
// op_ready low stalls EXE; rdata/rvalid return MFHI/MFLO results.
interface hilo_mult_ctrl_if;
   import hilo_mult_ctrl_pkg::*;

   logic              op_valid;
   op_e               op_type;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              op_ready;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;

   modport master (
      output op_valid, op_type, op_a, op_b,
      input  op_ready, rdata, rvalid
   );

   modport slave (
      input  op_valid, op_type, op_a, op_b,
      output op_ready, rdata, rvalid
   );

endinterface

// File: rtl/hilo_mult_ctrl.sv
// HI/LO register pair and launch/capture control for the iterative
// multiplier; stalls EXE while a multiply is in flight.
module hilo_mult_ctrl
   import hilo_mult_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                resetn,
   input  logic                cancel,
   hilo_mult_ctrl_if.slave     op,
   output logic                mult_begin,
   output logic                mult_sign,
   output logic [DATA_W-1:0]   mult_op1,
   output logic [DATA_W-1:0]   mult_op2,
   input  logic [2*DATA_W-1:0] mult_product,
   input  logic                mult_end,
   output logic [DATA_W-1:0]   hi,
   output logic [DATA_W-1:0]   lo,
   output logic                busy
);

   state_e            state;
   state_e            state_nxt;
   logic              accept;
   logic              launch;
   logic              hi_we;
   logic              lo_we;
   logic [DATA_W-1:0] hi_d;
   logic [DATA_W-1:0] lo_d;

   // A cancel in IDLE blocks acceptance so a flushed op leaves no trace.
   assign op.op_ready = (state == S_IDLE) & ~cancel;
   assign accept      = op.op_valid & op.op_ready;
   assign launch      = accept & is_mult(op.op_type);

   assign op.rvalid   = accept & is_mf(op.op_type);
   assign op.rdata    = (op.op_type == OP_MFHI) ? hi : lo;

   assign busy        = (state == S_BUSY);
   assign mult_begin  = busy;

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (launch) state_nxt = S_BUSY;
         S_BUSY: if (cancel || mult_end) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Cancel beats a coincident mult_end: the product is discarded.
   always_comb begin
      hi_we = 1'b0;
      lo_we = 1'b0;
      hi_d  = op.op_a;
      lo_d  = op.op_a;
      if (busy && mult_end && !cancel) begin
         hi_we = 1'b1;
         lo_we = 1'b1;
         hi_d  = mult_product[2*DATA_W-1:DATA_W];
         lo_d  = mult_product[DATA_W-1:0];
      end else if (accept) begin
         unique case (1'b1)
            (op.op_type == OP_MTHI): hi_we = 1'b1;
            (op.op_type == OP_MTLO): lo_we = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         hi        <= '0;
         lo        <= '0;
         mult_op1  <= '0;
         mult_op2  <= '0;
         mult_sign <= 1'b0;
      end else begin
         state <= state_nxt;
         if (launch) begin
            mult_op1  <= op.op_a;
            mult_op2  <= op.op_b;
            mult_sign <= (op.op_type == OP_MULT);
         end
         if (hi_we) hi <= hi_d;
         if (lo_we) lo <= lo_d;
      end
   end

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Directed bench for hilo_mult_ctrl with a behavioural early-terminating
// multiplier: mult_end arrives n+1 cycles after mult_begin rises.
module tb_hilo_mult_ctrl;
  import hilo_mult_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cancel;
  logic        mult_begin;
  logic        mult_sign;
  logic [31:0] mult_op1;
  logic [31:0] mult_op2;
  logic [63:0] mult_product;
  logic        mult_end;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  int n_asserts = 0;
  int n_fail    = 0;

  hilo_mult_ctrl_if opif ();

  hilo_mult_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .cancel       (cancel),
    .op           (opif),
    .mult_begin   (mult_begin),
    .mult_sign    (mult_sign),
    .mult_op1     (mult_op1),
    .mult_op2     (mult_op2),
    .mult_product (mult_product),
    .mult_end     (mult_end),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  logic        m_act;
  logic [5:0]  m_cnt;
  int          m_starts = 0;
  logic [63:0] e1, e2;

  function automatic int bitlen(input logic [31:0] b,
                                input logic s);
    logic [31:0] m;
    int r;
    m = (s && b[31]) ? -b : b;
    r = 0;
    for (int i = 0; i < 32; i++) if (m[i]) r = i + 1;
    return r;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_act <= 1'b0;
      m_cnt <= '0;
    end else if (!mult_begin) begin
      m_act <= 1'b0;
    end else if (!m_act) begin
      m_act    <= 1'b1;
      m_cnt    <= 6'(bitlen(mult_op2, mult_sign));
      m_starts <= m_starts + 1;
    end else if (mult_end) begin
      m_act <= 1'b0;
    end else begin
      m_cnt <= m_cnt - 6'd1;
    end
  end

  assign mult_end     = m_act && (m_cnt == 6'd0);
  assign e1           = mult_sign ? {{32{mult_op1[31]}}, mult_op1}
                                  : {32'h0, mult_op1};
  assign e2           = mult_sign ? {{32{mult_op2[31]}}, mult_op2}
                                  : {32'h0, mult_op2};
  assign mult_product = e1 * e2;

  task automatic chk(input string tag, input bit ok);
    n_asserts++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic put(input op_e t, input logic [31:0] a,
                     input logic [31:0] b);
    opif.op_valid = 1'b1;
    opif.op_type  = t;
    opif.op_a     = a;
    opif.op_b     = b;
  endtask

  task automatic idle_op();
    opif.op_valid = 1'b0;
    opif.op_type  = OP_NOP;
    opif.op_a     = '0;
    opif.op_b     = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts0;
    resetn = 1'b0;
    cancel = 1'b0;
    idle_op();
    smp();
    chk("rst_ready", opif.op_ready === 1'b1);
    chk("rst_busy", busy === 1'b0);
    chk("rst_begin", mult_begin === 1'b0);
    chk("rst_hi", hi === 32'h0);
    chk("rst_lo", lo === 32'h0);
    chk("rst_op1", mult_op1 === 32'h0);
    chk("rst_sign", mult_sign === 1'b0);
    chk("rst_rvalid", opif.rvalid === 1'b0);
    nc();
    resetn = 1'b1;
    nc();

    put(OP_MULT, 32'd7, 32'hFFFF_FFFD);
    smp();
    chk("t1_acc", opif.op_ready === 1'b1);
    for (int c = 1; c <= 5; c++) begin
      nc();
      if (c == 1) idle_op();
      smp();
      if (c == 1) begin
        chk("t1_begin", mult_begin === 1'b1);
        chk("t1_op1", mult_op1 === 32'd7);
        chk("t1_op2", mult_op2 === 32'hFFFF_FFFD);
        chk("t1_sign", mult_sign === 1'b1);
      end
      if (c <= 4) begin
        chk("t1_end", mult_end === 1'(c == 4));
        chk("t1_stall", opif.op_ready === 1'b0);
      end else begin
        chk("t1_hi", hi === 32'hFFFF_FFFF);
        chk("t1_lo", lo === 32'hFFFF_FFEB);
        chk("t1_ready", opif.op_ready === 1'b1);
        chk("t1_begin0", mult_begin === 1'b0);
      end
    end

    nc();
    put(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int c = 1; c <= 35; c++) begin
      nc();
      if (c == 1) put(OP_MFLO, 32'h0, 32'h0);
      smp();
      if (c <= 34) begin
        chk("t2_stall", opif.op_ready === 1'b0);
        chk("t2_rv0", opif.rvalid === 1'b0);
        chk("t2_end", mult_end === 1'(c == 34));
      end else begin
        chk("t2_hi", hi === 32'hFFFF_FFFE);
        chk("t2_lo", lo === 32'h0000_0001);
        chk("t2_ready", opif.op_ready === 1'b1);
        chk("t2_rvalid", opif.rvalid === 1'b1);
        chk("t2_rdata", opif.rdata === 32'h0000_0001);
      end
    end

    nc();
    put(OP_MULT, 32'd5, 32'd0);
    starts0 = m_starts;
    nc();
    idle_op();
    smp();
    chk("t3_end1", mult_end === 1'b0);
    nc();
    smp();
    chk("t3_end2", mult_end === 1'b1);
    nc();
    smp();
    chk("t3_begin0", mult_begin === 1'b0);
    chk("t3_hi", hi === 32'h0);
    chk("t3_lo", lo === 32'h0);
    nc();
    nc();
    smp();
    chk("t3_noend", mult_end === 1'b0);
    chk("t3_starts", m_starts == starts0 + 1);

    nc();
    put(OP_MTHI, 32'h1234, 32'h0);
    smp();
    chk("t4_mthi_rdy", opif.op_ready === 1'b1);
    nc();
    put(OP_MFHI, 32'h0, 32'h0);
    smp();
    chk("t4_mfhi_rdy", opif.op_ready === 1'b1);
    chk("t4_mfhi_rv", opif.rvalid === 1'b1);
    chk("t4_mfhi_d", opif.rdata === 32'h1234);
    nc();
    put(OP_MTLO, 32'h55, 32'h0);
    nc();
    put(OP_MFLO, 32'h0, 32'h0);
    smp();
    chk("t4_mflo_d", opif.rdata === 32'h55);
    chk("t4_mflo_rv", opif.rvalid === 1'b1);

    nc();
    put(OP_MTHI, 32'hDEAD, 32'h0);
    cancel = 1'b1;
    smp();
    chk("t5_icancel_rdy", opif.op_ready === 1'b0);
    nc();
    cancel = 1'b0;
    idle_op();
    smp();
    chk("t5_icancel_hi", hi === 32'h1234);

    nc();
    put(OP_MULT, 32'd3, 32'd3);
    nc();
    idle_op();
    nc();
    cancel = 1'b1;
    smp();
    chk("t5_c2_busy", busy === 1'b1);
    chk("t5_c2_rdy", opif.op_ready === 1'b0);
    nc();
    cancel = 1'b0;
    smp();
    chk("t5_c3_busy", busy === 1'b0);
    chk("t5_c3_begin", mult_begin === 1'b0);
    chk("t5_c3_hi", hi === 32'h1234);
    chk("t5_c3_lo", lo === 32'h55);

    nc();
    put(OP_MULT, 32'd1, 32'd1);
    nc();
    idle_op();
    nc();
    nc();
    cancel = 1'b1;
    smp();
    chk("t5_coinc_end", mult_end === 1'b1);
    nc();
    cancel = 1'b0;
    smp();
    chk("t5_coinc_hi", hi === 32'h1234);
    chk("t5_coinc_lo", lo === 32'h55);
    chk("t5_coinc_busy", busy === 1'b0);

    put(OP_MULT, 32'd2, 32'd2);
    nc();
    idle_op();
    nc();
    nc();
    nc();
    nc();
    smp();
    chk("t5_mul_lo", lo === 32'd4);
    chk("t5_mul_hi", hi === 32'd0);

    nc();
    put(OP_MULT, 32'd6, 32'd7);
    nc();
    idle_op();
    nc();
    resetn = 1'b0;
    smp();
    chk("t6_hi", hi === 32'h0);
    chk("t6_lo", lo === 32'h0);
    chk("t6_busy", busy === 1'b0);
    chk("t6_begin", mult_begin === 1'b0);
    nc();
    resetn = 1'b1;
    put(OP_MULT, 32'd2, 32'd3);
    smp();
    chk("t6_acc", opif.op_ready === 1'b1);
    nc();
    idle_op();
    smp();
    chk("t6_busy2", busy === 1'b1);
    nc();
    nc();
    nc();
    nc();
    smp();
    chk("t6_lo2", lo === 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule
